rom_port_sched: RTL and testbench

- Schedules the single ROM memory port of an arcade core between two requesters: the HPS ioctl download writer and the game CPU's instruction/data fetch.
- Sequences the core reset around a download: game_reset is held during the download and for a fixed tail afterwards.
- Sits between hps_io's ioctl outputs, the game core's ROM fetch interface, and a registered-read ROM/BRAM.

---
 rtl/rom_port_sched.sv | 169 ++++++++++++++++
 tb/tb_rom_port_sched.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_sched.sv
// Arbitrates one registered-read ROM port between the ioctl download writer and
// CPU fetches, and stretches the game reset over a download plus a fixed tail.
module rom_port_sched #(
    parameter int AW       = 16,
    parameter int ROM_SIZE = 65536,
    parameter int RST_HOLD = 16
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          dn_download,
    input  logic          dn_wr,
    input  logic [AW-1:0] dn_addr,
    input  logic [7:0]    dn_data,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_ack,
    output logic [7:0]    cpu_data,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [7:0]    mem_dout,
    output logic          game_reset,
    output logic [AW:0]   dl_count,
    output logic          dl_overflow
);

    localparam int HW = $clog2(RST_HOLD + 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RWAIT} state_t;

    state_t        state_q, state_d;

    logic          buf_valid_q, buf_valid_d;
    logic [AW-1:0] buf_addr_q, buf_addr_d;
    logic [7:0]    buf_data_q, buf_data_d;
    logic [AW:0]   dl_count_q, dl_count_d;
    logic          dl_overflow_q, dl_overflow_d;
    logic          dn_download_q;
    logic [HW-1:0] hold_q, hold_d;

    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]    mem_din_q, mem_din_d;
    logic          mem_we_q, mem_we_d;
    logic          mem_re_q, mem_re_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic [7:0]    cpu_data_q, cpu_data_d;

    logic          in_range;
    logic          drain;
    logic [AW:0]   count_base;

    assign in_range = (64'(dn_addr) < 64'(ROM_SIZE));
    assign drain    = (state_q == WRITE);

    // FSM: state register
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state; a pending buffered write always wins over a fetch
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (buf_valid_q) begin
                    state_d = WRITE;
                end else if (cpu_req && !dn_download) begin
                    state_d = READ;
                end
            end
            WRITE:   state_d = IDLE;
            READ:    state_d = RWAIT;
            RWAIT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: port outputs are registered, so they are decoded from the next state
    always_comb begin
        mem_we_d   = (state_d == WRITE);
        mem_re_d   = (state_d == READ);
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        if (state_d == WRITE) begin
            mem_addr_d = buf_addr_q;
            mem_din_d  = buf_data_q;
        end else if (state_d == READ) begin
            mem_addr_d = cpu_addr;
        end
        cpu_ack_d  = (state_q == RWAIT);
        cpu_data_d = (state_q == RWAIT) ? mem_dout : cpu_data_q;
    end

    // Write buffer, download byte counter and reset tail counter
    always_comb begin
        buf_valid_d   = buf_valid_q && !drain;
        buf_addr_d    = buf_addr_q;
        buf_data_d    = buf_data_q;
        dl_overflow_d = dl_overflow_q;
        count_base    = (dn_download && !dn_download_q) ? '0 : dl_count_q;
        dl_count_d    = count_base;
        if (dn_wr && in_range) begin
            if (!buf_valid_q || drain) begin
                buf_valid_d = 1'b1;
                buf_addr_d  = dn_addr;
                buf_data_d  = dn_data;
                if (!count_base[AW]) begin
                    dl_count_d = count_base + 1'b1;
                end
            end else begin
                dl_overflow_d = 1'b1;
            end
        end
        hold_d = hold_q;
        if (dn_download) begin
            hold_d = HW'(RST_HOLD);
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            buf_valid_q   <= 1'b0;
            buf_addr_q    <= '0;
            buf_data_q    <= '0;
            dl_count_q    <= '0;
            dl_overflow_q <= 1'b0;
            dn_download_q <= 1'b0;
            hold_q        <= HW'(RST_HOLD);
            mem_addr_q    <= '0;
            mem_din_q     <= '0;
            mem_we_q      <= 1'b0;
            mem_re_q      <= 1'b0;
            cpu_ack_q     <= 1'b0;
            cpu_data_q    <= '0;
        end else begin
            buf_valid_q   <= buf_valid_d;
            buf_addr_q    <= buf_addr_d;
            buf_data_q    <= buf_data_d;
            dl_count_q    <= dl_count_d;
            dl_overflow_q <= dl_overflow_d;
            dn_download_q <= dn_download;
            hold_q        <= hold_d;
            mem_addr_q    <= mem_addr_d;
            mem_din_q     <= mem_din_d;
            mem_we_q      <= mem_we_d;
            mem_re_q      <= mem_re_d;
            cpu_ack_q     <= cpu_ack_d;
            cpu_data_q    <= cpu_data_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_din     = mem_din_q;
    assign mem_we      = mem_we_q;
    assign mem_re      = mem_re_q;
    assign cpu_ack     = cpu_ack_q;
    assign cpu_data    = cpu_data_q;
    assign dl_count    = dl_count_q;
    assign dl_overflow = dl_overflow_q;
    assign game_reset  = dn_download || (hold_q != '0);

endmodule

// File: tb/tb_rom_port_sched.sv
// Directed bench for rom_port_sched with a registered-read BRAM model on the port.
module tb_rom_port_sched;

    localparam int AW = 16;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          dn_download;
    logic          dn_wr;
    logic [AW-1:0] dn_addr;
    logic [7:0]    dn_data;
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic          cpu_ack;
    logic [7:0]    cpu_data;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic          mem_we;
    logic          mem_re;
    logic [7:0]    mem_dout;
    logic          game_reset;
    logic [AW:0]   dl_count;
    logic          dl_overflow;

    int passed = 0;
    int total  = 0;

    logic [7:0] mem_arr [0:32767];
    logic [7:0] dl_bytes [4];

    rom_port_sched #(.AW(AW), .ROM_SIZE(32768), .RST_HOLD(16)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .dn_download (dn_download),
        .dn_wr       (dn_wr),
        .dn_addr     (dn_addr),
        .dn_data     (dn_data),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_ack     (cpu_ack),
        .cpu_data    (cpu_data),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_dout    (mem_dout),
        .game_reset  (game_reset),
        .dl_count    (dl_count),
        .dl_overflow (dl_overflow)
    );

    always #5 clk_sys = ~clk_sys;

    always_ff @(posedge clk_sys) begin
        if (mem_we) mem_arr[mem_addr[14:0]] <= mem_din;
        if (mem_re) mem_dout <= mem_arr[mem_addr[14:0]];
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, act, exp);
    endtask

    initial begin
        dl_bytes[0] = 8'h11; dl_bytes[1] = 8'h22; dl_bytes[2] = 8'h33; dl_bytes[3] = 8'h44;
        reset = 1'b1; dn_download = 1'b0; dn_wr = 1'b0; dn_addr = '0; dn_data = '0;
        cpu_req = 1'b0; cpu_addr = '0; mem_dout = '0;
        tick(); tick();
        check("rst_game_reset", game_reset, 1);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_re", mem_re, 0);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_cpu_data", cpu_data, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_dl_count", dl_count, 0);
        check("rst_dl_overflow", dl_overflow, 0);

        // Post-reset tail: 16 edges after release
        reset = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            check("post_rst_quiet", {30'd0, mem_we, mem_re}, 0);
        end
        check("post_rst_tail_high", game_reset, 1);
        tick();
        check("post_rst_tail_low", game_reset, 0);

        // Download of four bytes, one strobe every 4 cycles
        dn_download = 1'b1;
        tick();
        check("dl_game_reset", game_reset, 1);
        for (int i = 0; i < 4; i++) begin
            dn_addr = 16'(i); dn_data = dl_bytes[i]; dn_wr = 1'b1;
            tick();
            dn_wr = 1'b0;
            tick();
            check("dl_we", mem_we, 1);
            check("dl_addr", mem_addr, i);
            check("dl_din", mem_din, dl_bytes[i]);
            check("dl_re_excl", mem_re, 0);
            tick();
            check("dl_we_off", mem_we, 0);
            tick();
        end
        check("dl_count_4", dl_count, 4);

        // Out-of-range byte is dropped
        dn_addr = 16'hFFFF; dn_data = 8'hEE; dn_wr = 1'b1;
        tick();
        dn_wr = 1'b0;
        tick();
        check("oor_no_we", mem_we, 0);
        tick();
        check("oor_no_we2", mem_we, 0);
        check("oor_count", dl_count, 4);

        // Download end: game_reset tail of exactly 16 cycles
        dn_download = 1'b0;
        #1;
        check("tail_start", game_reset, 1);
        for (int i = 1; i <= 15; i++) tick();
        check("tail_15", game_reset, 1);
        tick();
        check("tail_16", game_reset, 0);

        // CPU read of 0x0002
        cpu_req = 1'b1; cpu_addr = 16'h0002;
        tick();
        check("rd_re", mem_re, 1);
        check("rd_addr", mem_addr, 16'h0002);
        check("rd_we_excl", mem_we, 0);
        tick();
        check("rd_re_off", mem_re, 0);
        check("rd_ack_early", cpu_ack, 0);
        tick();
        check("rd_ack", cpu_ack, 1);
        check("rd_data", cpu_data, 8'h33);
        cpu_req = 1'b0;
        tick();
        check("rd_ack_pulse", cpu_ack, 0);
        check("rd_data_hold", cpu_data, 8'h33);
        check("rd_no_rereq", mem_re, 0);

        // Request during download is held off until it ends
        dn_download = 1'b1; cpu_req = 1'b1; cpu_addr = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("dlrd_blocked", mem_re, 0);
        end
        dn_download = 1'b0;
        tick();
        check("dlrd_re", mem_re, 1);
        check("dlrd_addr", mem_addr, 16'h0001);
        tick();
        check("dlrd_ack_early", cpu_ack, 0);
        tick();
        check("dlrd_ack", cpu_ack, 1);
        check("dlrd_data", cpu_data, 8'h22);
        cpu_req = 1'b0;
        tick();
        check("dlrd_ack_pulse", cpu_ack, 0);

        // Back-to-back strobes while a read holds the buffer full
        cpu_req = 1'b1; cpu_addr = 16'h0000;
        tick();
        check("ovf_re", mem_re, 1);
        dn_download = 1'b1; dn_wr = 1'b1; dn_addr = 16'h0010; dn_data = 8'hA5;
        tick();
        check("ovf_no_we_rwait", mem_we, 0);
        dn_addr = 16'h0011; dn_data = 8'h5A;
        tick();
        check("ovf_ack", cpu_ack, 1);
        check("ovf_data", cpu_data, 8'h11);
        check("ovf_flag", dl_overflow, 1);
        check("ovf_count", dl_count, 1);
        cpu_req = 1'b0; dn_wr = 1'b0;
        tick();
        check("ovf_we", mem_we, 1);
        check("ovf_we_addr", mem_addr, 16'h0010);
        check("ovf_we_din", mem_din, 8'hA5);
        tick();
        check("ovf_we_once", mem_we, 0);
        dn_download = 1'b0;
        tick(); tick(); tick();
        check("ovf_sticky", dl_overflow, 1);
        check("ovf_no_second_we", mem_we, 0);

        // Asynchronous reset during a read aborts it
        cpu_req = 1'b1; cpu_addr = 16'h0002;
        tick();
        check("ar_re", mem_re, 1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_re_cleared", mem_re, 0);
        check("ar_game_reset", game_reset, 1);
        check("ar_overflow_clr", dl_overflow, 0);
        check("ar_count_clr", dl_count, 0);
        cpu_req = 1'b0;
        tick(); tick();
        check("ar_no_ack", cpu_ack, 0);
        check("ar_no_data", cpu_data, 0);
        reset = 1'b0;
        tick();
        check("ar_idle_after", {30'd0, mem_we, mem_re}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
